mole_slot_scheduler: RTL

- Per-slot lifecycle controller for the mole field: owns the 2-bit state of each mole slot (OFFSCREEN, ONSCREEN, HIT, MISS) and its lifetime.
- Sequences spawn requests from the mole generator, player hits and timeouts.
- Sits between the mole generator / rate divider and the score, display and match logic.
- Driven by the main game FSM through `enable`, which is high only while INGAME.

---
 rtl/mole_slot_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mole_slot_scheduler.sv
// Per-slot lifecycle controller for the mole field: spawn, hit, timeout and
// display sequencing of every slot, plus the hit/miss event outputs.
module mole_slot_scheduler #(
   parameter int unsigned NUM_MOLES      = 5,
   parameter int unsigned LIFETIME_TICKS = 3,
   parameter int unsigned SHOW_TICKS     = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     tick,
   input  logic [NUM_MOLES-1:0]     spawnMask,
   input  logic                     hitValid,
   input  logic [2:0]               hitIndex,
   output logic [2*NUM_MOLES-1:0]   moleState,
   output logic [NUM_MOLES-1:0]     molesVisible,
   output logic                     hitPulse,
   output logic [2:0]               hitSlot,
   output logic                     badHitPulse,
   output logic                     missPulse,
   output logic [7:0]               missCount
);

   typedef enum logic [1:0] {
      OFFSCREEN = 2'd0,
      ONSCREEN  = 2'd1,
      HIT       = 2'd2,
      MISS      = 2'd3
   } slotState_t;

   localparam logic [3:0] LIFE_INIT = 4'(LIFETIME_TICKS);
   localparam logic [3:0] SHOW_INIT = 4'(SHOW_TICKS);

   slotState_t           state     [NUM_MOLES];
   slotState_t           stateNext [NUM_MOLES];
   logic [3:0]           life      [NUM_MOLES];
   logic [3:0]           lifeNext  [NUM_MOLES];
   logic [3:0]           show      [NUM_MOLES];
   logic [3:0]           showNext  [NUM_MOLES];
   logic [NUM_MOLES-1:0] timeoutVec;
   logic [NUM_MOLES-1:0] visibleNext;
   logic                 goodHit;
   logic                 badHit;
   logic [2:0]           hitSlotNext;
   logic [3:0]           missInc;
   logic [8:0]           missSum;
   logic [7:0]           missCountNext;

   always_comb begin
      goodHit     = 1'b0;
      hitSlotNext = hitSlot;
      timeoutVec  = '0;
      visibleNext = '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) begin
         stateNext[i] = state[i];
         lifeNext[i]  = life[i];
         showNext[i]  = show[i];
         if (!enable) begin
            stateNext[i] = OFFSCREEN;
            lifeNext[i]  = '0;
            showNext[i]  = '0;
         end else begin
            case (state[i])
               OFFSCREEN: begin
                  if (tick && spawnMask[i]) begin
                     stateNext[i] = ONSCREEN;
                     lifeNext[i]  = LIFE_INIT;
                  end
               end
               ONSCREEN: begin
                  // A hit takes priority over a simultaneous final tick.
                  if (hitValid && (hitIndex == 3'(i))) begin
                     stateNext[i] = HIT;
                     showNext[i]  = SHOW_INIT;
                     lifeNext[i]  = '0;
                     goodHit      = 1'b1;
                     hitSlotNext  = 3'(i);
                  end else if (tick) begin
                     if (life[i] == 4'd1) begin
                        stateNext[i]  = MISS;
                        showNext[i]   = SHOW_INIT;
                        lifeNext[i]   = '0;
                        timeoutVec[i] = 1'b1;
                     end else begin
                        lifeNext[i] = life[i] - 4'd1;
                     end
                  end
               end
               HIT, MISS: begin
                  if (tick) begin
                     if (show[i] == 4'd1) begin
                        stateNext[i] = OFFSCREEN;
                        showNext[i]  = '0;
                     end else begin
                        showNext[i] = show[i] - 4'd1;
                     end
                  end
               end
               default: stateNext[i] = OFFSCREEN;
            endcase
         end
         visibleNext[i] = (stateNext[i] == ONSCREEN);
      end

      badHit = enable && hitValid && !goodHit;

      missInc = '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) begin
         missInc = missInc + {3'b000, timeoutVec[i]};
      end
      missSum = {1'b0, missCount} + {5'b00000, missInc};

      if (!enable) begin
         missCountNext = '0;
      end else if (missSum[8]) begin
         missCountNext = '1;
      end else begin
         missCountNext = missSum[7:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            state[i] <= OFFSCREEN;
            life[i]  <= '0;
            show[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_MOLES; i++) begin
            state[i] <= stateNext[i];
            life[i]  <= lifeNext[i];
            show[i]  <= showNext[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         molesVisible <= '0;
         hitPulse     <= 1'b0;
         hitSlot      <= '0;
         badHitPulse  <= 1'b0;
         missPulse    <= 1'b0;
         missCount    <= '0;
      end else begin
         molesVisible <= visibleNext;
         hitPulse     <= goodHit;
         hitSlot      <= hitSlotNext;
         badHitPulse  <= badHit;
         missPulse    <= |timeoutVec;
         missCount    <= missCountNext;
      end
   end

   // The slot registers themselves form the state output; this is wiring only.
   always_comb begin
      moleState = '0;
      for (int unsigned i = 0; i < NUM_MOLES; i++) begin
         moleState[2*i +: 2] = state[i];
      end
   end

endmodule
